// File: rtl/gb_dma_pkg.sv
// Shared constants, state encoding and source-page folding for the OAM DMA controller.
package gb_dma_pkg;

   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam int unsigned XFER_LEN     = 160;
   localparam int unsigned MCYCLE       = 4;
   localparam int unsigned IDX_W        = 8;
   localparam int unsigned PH_W         = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      XFER  = 2'd2
   } dma_state_t;

   // Pages E0..FF are the echo of WRAM and fold down onto C0..DF.
   function automatic logic [7:0] echo_fold(input logic [7:0] page);
      echo_fold = (page >= 8'hE0) ? 8'(page - 8'h20) : page;
   endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine: decodes FF46 writes, copies one page into OAM a byte per M-cycle,
// and owns the external bus (blocking the CPU) while the copy runs.
module oam_dma_ctrl #(
   parameter int unsigned XFER_LEN     = gb_dma_pkg::XFER_LEN,
   parameter int unsigned MCYCLE       = gb_dma_pkg::MCYCLE,
   parameter logic [15:0] DMA_REG_ADDR = gb_dma_pkg::DMA_REG_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_d_out,
   input  logic        cpu_wr,
   input  logic        cpu_rd,
   output logic [7:0]  cpu_d_in,
   output logic [15:0] A,
   output logic [7:0]  D_out,
   output logic        WR,
   output logic        RD,
   input  logic [7:0]  D_in,
   output logic [7:0]  oam_a,
   output logic [7:0]  oam_d,
   output logic        oam_we,
   output logic [7:0]  dma_reg,
   output logic        dma_active
);
   import gb_dma_pkg::*;

   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_START = 2'(START);
   localparam logic [1:0] S_XFER  = 2'(XFER);

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(MCYCLE - 1);
   localparam logic [PH_W-1:0]  PH_CAP   = PH_W'(MCYCLE - 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic [PH_W-1:0]  cnt_q, cnt_d;
   logic [7:0]       src_q;
   logic [7:0]       data_q;
   logic             hit_q;
   logic             reg_hit_c;
   logic             trigger_c;
   logic             capture_c;

   assign reg_hit_c = cpu_wr && (cpu_a == DMA_REG_ADDR);
   assign trigger_c = reg_hit_c && !hit_q;
   assign capture_c = (state_q == S_XFER) && (phase_q == PH_CAP);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         phase_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state; a fresh FF46 write restarts from START whatever the current state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      if (trigger_c) begin
         state_d = S_START;
         idx_d   = '0;
         phase_d = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_START: begin
               if (cnt_q == PH_LAST) begin
                  state_d = S_XFER;
                  idx_d   = '0;
                  phase_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_XFER: begin
               phase_d = phase_q + 1'b1;
               if (phase_q == PH_LAST) begin
                  if (idx_q == IDX_LAST) begin
                     state_d = S_IDLE;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Register file, read capture and the registered OAM write port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_q      <= 1'b0;
         dma_reg    <= 8'hFF;
         src_q      <= '0;
         data_q     <= '0;
         oam_we     <= 1'b0;
         oam_a      <= '0;
         oam_d      <= '0;
         dma_active <= 1'b0;
      end else begin
         hit_q      <= reg_hit_c;
         dma_active <= (state_d == S_XFER);
         if (trigger_c) begin
            dma_reg <= cpu_d_out;
            src_q   <= echo_fold(cpu_d_out);
         end
         if (capture_c) begin
            data_q <= D_in;
         end
         // A byte abandoned by a retrigger before its write phase is never written.
         oam_we <= capture_c && !trigger_c;
         if (capture_c && !trigger_c) begin
            oam_a <= idx_q;
            oam_d <= D_in;
         end
      end
   end

   // External bus ownership: pass-through unless a transfer is in flight.
   always_comb begin
      A        = cpu_a;
      D_out    = cpu_d_out;
      WR       = cpu_wr;
      RD       = cpu_rd;
      cpu_d_in = D_in;
      if (state_q == S_XFER) begin
         A        = {src_q, idx_q};
         D_out    = '0;
         WR       = 1'b0;
         RD       = (phase_q != PH_LAST);
         cpu_d_in = 8'hFF;
      end
   end

endmodule
